// File: rtl/smart_home_pkg.sv
// Shared widths, reset defaults and receiver state encoding for the sensor front-end.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package smart_home_pkg;

   localparam int TEMP_W        = 7;
   localparam int TS_FRAME_BITS = 8;

   localparam logic [TEMP_W-1:0] T_RST_DEF = 7'd20;

   typedef enum logic [1:0] {
      RX_IDLE  = 2'd0,
      RX_SHIFT = 2'd1,
      RX_CHECK = 2'd2
   } rx_state_t;

endpackage

// File: rtl/sensor_debounce.sv
// Synchronizes one asynchronous contact and debounces it to a clean level.
// Latency: change first sampled at edge k reaches level at edge k+1+DEB_CYCLES.
// Backpressure: none; the contact is sampled every cycle.
module sensor_debounce #(
   parameter int DEB_CYCLES = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic level
);

   localparam int CW = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;

   logic          meta;
   logic          sync;
   logic [CW-1:0] cnt;

   // Two-flop synchronizer for the asynchronous contact.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta <= 1'b0;
         sync <= 1'b0;
      end else begin
         meta <= raw;
         sync <= meta;
      end
   end

   // Count consecutive cycles of disagreement; flip only once it has persisted long enough.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt   <= '0;
         level <= 1'b0;
      end else if (sync != level) begin
         if (cnt == CW'(DEB_CYCLES - 1)) begin
            level <= ~level;
            cnt   <= '0;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end else begin
         cnt <= '0;
      end
   end

endmodule

// File: rtl/smart_home_sensor_if.sv
// Conditions door/window/fire contacts and receives the framed serial temperature.
// Latency: contacts k+1+DEB_CYCLES; temperature result 3 edges after cs_n rise is sampled.
// Backpressure: none; outputs are levels and single-cycle pulses.
module smart_home_sensor_if
   import smart_home_pkg::*;
#(
   parameter int                DEB_CYCLES = 4,
   parameter logic [TEMP_W-1:0] T_RST      = T_RST_DEF
) (
   input  logic              clk,
   input  logic              Rst,
   input  logic              raw_fd,
   input  logic              raw_rd,
   input  logic              raw_w,
   input  logic              raw_fa,
   input  logic              ts_cs_n,
   input  logic              ts_sclk,
   input  logic              ts_sdata,
   output logic              SFD,
   output logic              SRD,
   output logic              SW,
   output logic              SFA,
   output logic [TEMP_W-1:0] ST,
   output logic              st_upd,
   output logic              frm_err
);

   sensor_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_fd (.clk(clk), .rst(Rst), .raw(raw_fd), .level(SFD));
   sensor_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_rd (.clk(clk), .rst(Rst), .raw(raw_rd), .level(SRD));
   sensor_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_w  (.clk(clk), .rst(Rst), .raw(raw_w),  .level(SW));
   sensor_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_fa (.clk(clk), .rst(Rst), .raw(raw_fa), .level(SFA));

   logic cs_meta, cs_sync, cs_prev;
   logic sclk_meta, sclk_sync, sclk_prev;
   logic sd_meta, sd_sync;

   // Synchronize the serial lines; data shares the clock's latency so bits stay aligned.
   always_ff @(posedge clk or posedge Rst) begin
      if (Rst) begin
         cs_meta   <= 1'b0;
         cs_sync   <= 1'b0;
         cs_prev   <= 1'b0;
         sclk_meta <= 1'b0;
         sclk_sync <= 1'b0;
         sclk_prev <= 1'b0;
         sd_meta   <= 1'b0;
         sd_sync   <= 1'b0;
      end else begin
         cs_meta   <= ts_cs_n;
         cs_sync   <= cs_meta;
         cs_prev   <= cs_sync;
         sclk_meta <= ts_sclk;
         sclk_sync <= sclk_meta;
         sclk_prev <= sclk_sync;
         sd_meta   <= ts_sdata;
         sd_sync   <= sd_meta;
      end
   end

   logic cs_fall, cs_rise, sclk_rise;
   assign cs_fall   = cs_prev & ~cs_sync;
   assign cs_rise   = ~cs_prev & cs_sync;
   assign sclk_rise = ~sclk_prev & sclk_sync;

   rx_state_t                state;
   logic [TS_FRAME_BITS-1:0] shreg;
   logic [3:0]               bit_cnt;

   // Frame receiver: collect bits between cs_n edges, then accept or reject in CHECK.
   always_ff @(posedge clk or posedge Rst) begin
      if (Rst) begin
         state   <= RX_IDLE;
         shreg   <= '0;
         bit_cnt <= '0;
         ST      <= T_RST;
         st_upd  <= 1'b0;
         frm_err <= 1'b0;
      end else begin
         st_upd  <= 1'b0;
         frm_err <= 1'b0;
         case (state)
            RX_IDLE: begin
               if (cs_fall) begin
                  state   <= RX_SHIFT;
                  shreg   <= '0;
                  bit_cnt <= '0;
               end
            end
            RX_SHIFT: begin
               // End-of-frame takes priority; a coincident clock edge is dropped.
               if (cs_rise) begin
                  state <= RX_CHECK;
               end else if (sclk_rise) begin
                  shreg <= {shreg[TS_FRAME_BITS-2:0], sd_sync};
                  if (bit_cnt != 4'd9) begin
                     bit_cnt <= bit_cnt + 4'd1;
                  end
               end
            end
            RX_CHECK: begin
               state <= RX_IDLE;
               if (bit_cnt == 4'(TS_FRAME_BITS) && (^shreg) == 1'b0) begin
                  ST     <= shreg[TS_FRAME_BITS-1:1];
                  st_upd <= 1'b1;
               end else if (bit_cnt != 4'd0) begin
                  frm_err <= 1'b1;
               end
            end
            default: state <= RX_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_smart_home_sensor_if.sv
// Directed bench for the sensor front-end: contacts, debounce timing and temperature frames.
// Latency: checks pin exact edge counts for debounce and frame results.
// Backpressure: n/a.
module tb_smart_home_sensor_if;

   logic       clk;
   logic       Rst;
   logic       raw_fd, raw_rd, raw_w, raw_fa;
   logic       ts_cs_n, ts_sclk, ts_sdata;
   logic       SFD, SRD, SW, SFA;
   logic [6:0] ST;
   logic       st_upd, frm_err;

   int checks;
   int failures;

   smart_home_sensor_if dut (
      .clk      (clk),
      .Rst      (Rst),
      .raw_fd   (raw_fd),
      .raw_rd   (raw_rd),
      .raw_w    (raw_w),
      .raw_fa   (raw_fa),
      .ts_cs_n  (ts_cs_n),
      .ts_sclk  (ts_sclk),
      .ts_sdata (ts_sdata),
      .SFD      (SFD),
      .SRD      (SRD),
      .SW       (SW),
      .SFA      (SFA),
      .ST       (ST),
      .st_upd   (st_upd),
      .frm_err  (frm_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Advance k clock edges, then settle 1 ns past the last edge.
   task automatic cyc(input int k);
      repeat (k) @(posedge clk);
      #1;
   endtask

   task automatic chk_contacts(input string tag, input logic v);
      chk({tag, "_sfd"}, 32'(SFD), 32'(v));
      chk({tag, "_srd"}, 32'(SRD), 32'(v));
      chk({tag, "_sw"},  32'(SW),  32'(v));
      chk({tag, "_sfa"}, 32'(SFA), 32'(v));
   endtask

   // Send n bits of word MSB first; sim_end raises cs_n together with the last sclk rise.
   task automatic send_frame(input logic [15:0] word, input int n, input bit sim_end);
      logic [15:0] w;
      w = word;
      ts_cs_n = 1'b0;
      cyc(4);
      for (int i = n - 1; i >= 0; i--) begin
         ts_sdata = w[i];
         ts_sclk  = 1'b0;
         cyc(4);
         if (sim_end && i == 0) begin
            ts_sclk = 1'b1;
            ts_cs_n = 1'b1;
            return;
         end
         ts_sclk = 1'b1;
         cyc(4);
         ts_sclk = 1'b0;
      end
      cyc(4);
      ts_cs_n = 1'b1;
   endtask

   // Called right after cs_n was raised; result lands on the 4th edge after that drive.
   task automatic finish_frame(input string tag, input logic exp_upd, input logic exp_err,
                               input logic [6:0] prev_st, input logic [6:0] exp_st);
      cyc(3);
      chk({tag, "_pre_upd"}, 32'(st_upd), 32'(0));
      chk({tag, "_pre_err"}, 32'(frm_err), 32'(0));
      chk({tag, "_pre_st"},  32'(ST), 32'(prev_st));
      cyc(1);
      chk({tag, "_upd"}, 32'(st_upd), 32'(exp_upd));
      chk({tag, "_err"}, 32'(frm_err), 32'(exp_err));
      chk({tag, "_st"},  32'(ST), 32'(exp_st));
      cyc(1);
      chk({tag, "_post_upd"}, 32'(st_upd), 32'(0));
      chk({tag, "_post_err"}, 32'(frm_err), 32'(0));
      chk({tag, "_post_st"},  32'(ST), 32'(exp_st));
      ts_sclk = 1'b0;
      cyc(4);
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      Rst      = 1'b1;
      raw_fd   = 1'b0;
      raw_rd   = 1'b0;
      raw_w    = 1'b0;
      raw_fa   = 1'b0;
      ts_cs_n  = 1'b1;
      ts_sclk  = 1'b0;
      ts_sdata = 1'b0;

      // Reset state
      #12;
      chk_contacts("rst0", 1'b0);
      chk("rst0_st", 32'(ST), 32'(20));
      chk("rst0_upd", 32'(st_upd), 32'(0));
      chk("rst0_err", 32'(frm_err), 32'(0));
      cyc(2);
      Rst    = 1'b0;
      raw_fd = 1'b1;
      raw_rd = 1'b1;
      raw_w  = 1'b1;
      raw_fa = 1'b1;
      cyc(10);
      chk_contacts("contacts_hi", 1'b1);

      // Valid frame 1111000_0 -> 120; contacts undisturbed
      send_frame(16'b1111_0000, 8, 1'b0);
      finish_frame("frm120", 1'b1, 1'b0, 7'd20, 7'd120);
      chk_contacts("frm120", 1'b1);

      // Reset asserted mid-frame with contacts high
      ts_cs_n = 1'b0;
      cyc(4);
      ts_sdata = 1'b1;
      ts_sclk  = 1'b1;
      cyc(4);
      ts_sclk = 1'b0;
      cyc(2);
      #2 Rst = 1'b1;
      #1;
      chk_contacts("rst_mid", 1'b0);
      chk("rst_mid_st", 32'(ST), 32'(20));
      chk("rst_mid_upd", 32'(st_upd), 32'(0));
      chk("rst_mid_err", 32'(frm_err), 32'(0));
      cyc(2);
      Rst    = 1'b0;
      raw_fd = 1'b0;
      raw_rd = 1'b0;
      raw_w  = 1'b0;
      raw_fa = 1'b0;
      cyc(4);
      ts_sclk = 1'b1;
      cyc(4);
      ts_sclk = 1'b0;
      cyc(4);
      ts_cs_n = 1'b1;
      finish_frame("abandon", 1'b0, 1'b0, 7'd20, 7'd20);

      // First full frame after reset: 0100110_1 -> 38
      send_frame(16'b0100_1101, 8, 1'b0);
      finish_frame("frm38", 1'b1, 1'b0, 7'd20, 7'd38);
      chk_contacts("after_rst", 1'b0);

      // Glitch of 3 cycles is filtered
      raw_w = 1'b1;
      cyc(3);
      raw_w = 1'b0;
      cyc(10);
      chk("glitch_sw", 32'(SW), 32'(0));

      // Held high: output flips on exactly the 6th edge after the drive (k+5)
      raw_w = 1'b1;
      cyc(5);
      chk("rise_k4_sw", 32'(SW), 32'(0));
      cyc(1);
      chk("rise_k5_sw", 32'(SW), 32'(1));
      chk("rise_k5_sfd", 32'(SFD), 32'(0));

      // Held low: same latency back to 0
      raw_w = 1'b0;
      cyc(5);
      chk("fall_k4_sw", 32'(SW), 32'(1));
      cyc(1);
      chk("fall_k5_sw", 32'(SW), 32'(0));

      // Parity error 0100110_0
      send_frame(16'b0100_1100, 8, 1'b0);
      finish_frame("parity", 1'b0, 1'b1, 7'd38, 7'd38);

      // Short frame: 7 bits
      send_frame(16'b010_0110, 7, 1'b0);
      finish_frame("len7", 1'b0, 1'b1, 7'd38, 7'd38);

      // Long frame: 9 bits, otherwise valid-looking
      send_frame(16'b1_1111_0000, 9, 1'b0);
      finish_frame("len9", 1'b0, 1'b1, 7'd38, 7'd38);

      // Empty frame: cs_n toggles with no sclk
      send_frame(16'b0, 0, 1'b0);
      finish_frame("empty", 1'b0, 1'b0, 7'd38, 7'd38);

      // 9th sclk rise coincides with cs_n rise: dropped, 0000011_0 -> 3 accepted
      send_frame(16'b0_0000_0110 << 1 | 16'd1, 9, 1'b1);
      finish_frame("simult", 1'b1, 1'b0, 7'd38, 7'd3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Global watchdog so the run always terminates.
   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
